mig_ui_responder: RTL

Synthesizable responder for the MIG user interface (UI): it stands in for the DDR3 memory controller, accepting app_* read/write commands and returning read data with fixed latency from an on-chip word array. It sits on the UI clock domain in place of the MIG, and is driven directly by the frame-buffer traffic generator in simulation and in the DRAM-less bring-up build. It models calibration delay, command back-pressure and, optionally, refresh stalls.

---
 rtl/mig_ui_responder_if.sv | 23 ++
 rtl/mig_ui_responder.sv | 93 +++++++++
 2 files changed

// File: rtl/mig_ui_responder_if.sv
// mig_ui_responder_if: MIG user-interface command, write-data and read-data signals
interface mig_ui_responder_if;
  logic [26:0] app_addr;
  logic [2:0] app_cmd;
  logic app_en;
  logic [127:0] app_wdf_data;
  logic app_wdf_end;
  logic app_wdf_wren;
  logic [15:0] app_wdf_mask;
  logic app_rdy;
  logic app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic app_rd_data_valid;
  logic app_rd_data_end;
  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren, app_wdf_mask,
    input app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
  modport slave (
    input app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren, app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/mig_ui_responder.sv
// mig_ui_responder: on-chip MIG UI stand-in with calibration delay and fixed read latency; define MIG_UI_RESPONDER_REFRESH_EN for periodic refresh stalls
module mig_ui_responder #(
  parameter int DEPTH_WORDS = 16384,
  parameter int CALIB_CYCLES = 64,
  parameter int RD_LATENCY = 8,
  parameter int MAX_INFLIGHT = 16,
  parameter int REF_PERIOD = 1024,
  parameter int REF_STALL = 16
) (
  input logic clk_in,
  input logic rst_n_in,
  mig_ui_responder_if.slave ui,
  output logic init_calib_complete,
  output logic [2:0] err_flags
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int TA = CALIB_CYCLES > REF_PERIOD ? CALIB_CYCLES : REF_PERIOD;
  localparam int TM = TA > REF_STALL ? TA : REF_STALL;
  localparam int TW = $clog2(TM + 1);
`ifdef MIG_UI_RESPONDER_REFRESH_EN
  typedef enum logic [1:0] {CALIB, RUN, REFRESH} state_t;
`else
  typedef enum logic [0:0] {CALIB, RUN} state_t;
`endif
  state_t state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [CW-1:0] inflight;
  logic [RD_LATENCY-1:0] vld;
  logic [127:0] pipe [RD_LATENCY];
  logic [127:0] mem [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic run, cmd_ok, wr_cmd, wr_acc, rd_acc, wr_viol, ret;
  assign run = state == RUN;
  assign idx = IW'(ui.app_addr[26:3] % 24'(DEPTH_WORDS));
  assign ui.app_wdf_rdy = run;
  assign ui.app_rdy = run && inflight < CW'(MAX_INFLIGHT);
  assign cmd_ok = ui.app_en && ui.app_rdy;
  assign wr_cmd = cmd_ok && ui.app_cmd == 3'b000;
  assign rd_acc = cmd_ok && ui.app_cmd == 3'b001;
  assign wr_acc = wr_cmd && ui.app_wdf_wren;
  // a data beat must pair with an accepted write command, and every write is a single (end) beat
  assign wr_viol = (ui.app_wdf_wren != wr_cmd) || (ui.app_wdf_wren && !ui.app_wdf_end);
  assign ret = vld[RD_LATENCY-1];
  assign ui.app_rd_data_valid = ret;
  assign ui.app_rd_data_end = ret;
  assign ui.app_rd_data = pipe[RD_LATENCY-1];
  assign init_calib_complete = state != CALIB;
  // one shared timer counts calibration, run time between refreshes, and the refresh stall
  always_comb begin
    state_nxt = state;
    tmr_nxt = tmr + TW'(1);
    if (state == CALIB && tmr == TW'(CALIB_CYCLES - 1)) begin
      state_nxt = RUN;
      tmr_nxt = '0;
    end
`ifdef MIG_UI_RESPONDER_REFRESH_EN
    if (state == RUN && tmr == TW'(REF_PERIOD - 1)) begin
      state_nxt = REFRESH;
      tmr_nxt = '0;
    end
    if (state == REFRESH && tmr == TW'(REF_STALL - 1)) begin
      state_nxt = RUN;
      tmr_nxt = '0;
    end
`else
    if (run) tmr_nxt = tmr;
`endif
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= CALIB;
      tmr <= '0;
      inflight <= '0;
      vld <= '0;
      err_flags <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
    end else begin
      state <= state_nxt;
      tmr <= tmr_nxt;
      inflight <= inflight + CW'(rd_acc) - CW'(ret);
      vld <= {vld[RD_LATENCY-2:0], rd_acc};
      pipe[0] <= rd_acc ? mem[idx] : pipe[0];
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
      err_flags <= err_flags | {wr_viol, ui.app_en && |ui.app_cmd[2:1], (wr_cmd || rd_acc) && |ui.app_addr[2:0]};
    end
  end
  always_ff @(posedge clk_in) begin
    if (wr_acc)
      for (int b = 0; b < 16; b++)
        if (!ui.app_wdf_mask[b]) mem[idx][8*b +: 8] <= ui.app_wdf_data[8*b +: 8];
  end
endmodule
